// File: rtl/stream_demux.sv
// stream_demux: steers one valid/ready stream to N_OUT registered output slots.
// Optional build macro STREAM_DEMUX_ROUND_ROBIN_EN: steer by an internal round-robin pointer instead of up_sel.
module stream_demux #(
    parameter int unsigned  N_OUT = 4,
    parameter int unsigned  W     = 8,
    localparam int unsigned SEL_W = $clog2(N_OUT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               up_valid,
    output logic               up_ready,
    input  logic [W-1:0]       up_data,
    input  logic [SEL_W-1:0]   up_sel,
    output logic [N_OUT-1:0]   dn_valid,
    input  logic [N_OUT-1:0]   dn_ready,
    output logic [N_OUT*W-1:0] dn_data,
    output logic               err_sel
);

    logic [N_OUT-1:0] r_valid;
    logic [W-1:0]     r_data [N_OUT];

    logic [SEL_W-1:0] w_dest;
    logic             w_in_range;
    logic             w_dest_ready;
    logic             w_accept;
    logic [N_OUT-1:0] w_load;

`ifdef STREAM_DEMUX_ROUND_ROBIN_EN
    logic [SEL_W-1:0] r_rr_ptr;
    logic             w_unused_sel;

    assign w_dest       = r_rr_ptr;
    assign w_unused_sel = ^up_sel;
`else
    assign w_dest = up_sel;
`endif

    // Destination decode and upstream handshake; out-of-range beats are always taken and dropped.
    always_comb begin
        w_in_range   = ({1'b0, w_dest} < (SEL_W+1)'(N_OUT));
        w_dest_ready = 1'b0;
        for (int i = 0; i < int'(N_OUT); i++) begin
            if (w_dest == SEL_W'(i)) begin
                w_dest_ready = ~r_valid[i] | dn_ready[i];
            end
        end
        up_ready = w_in_range ? w_dest_ready : 1'b1;
        w_accept = up_valid & up_ready;
        w_load   = '0;
        for (int i = 0; i < int'(N_OUT); i++) begin
            w_load[i] = w_accept & w_in_range & (w_dest == SEL_W'(i));
        end
    end

    // Per-channel slot: a load wins over a drain, giving replace-without-bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < int'(N_OUT); i++) begin
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N_OUT); i++) begin
                if (w_load[i]) begin
                    r_valid[i] <= 1'b1;
                    r_data[i]  <= up_data;
                end else if (dn_ready[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

`ifdef STREAM_DEMUX_ROUND_ROBIN_EN
    // Pointer moves only on an accepted beat so channel order is never skipped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= (r_rr_ptr == SEL_W'(N_OUT - 1)) ? '0 : r_rr_ptr + SEL_W'(1);
        end
    end

    assign err_sel = 1'b0;
`else
    logic r_err_sel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_sel <= 1'b0;
        end else if (w_accept && !w_in_range) begin
            r_err_sel <= 1'b1;
        end
    end

    assign err_sel = r_err_sel;
`endif

    assign dn_valid = r_valid;

    for (genvar g = 0; g < int'(N_OUT); g++) begin : g_pack
        assign dn_data[g*W +: W] = r_data[g];
    end

endmodule
